// File: rtl/oam_dma.sv
// Sprite DMA: halts the CPU and copies page XX00-XXFF to the OAM data port; passes CPU traffic through when idle.
// Latency: trigger cycle N, HALT in N+1, first READ in N+2 (or N+3 after ALIGN); 513/514 stolen cycles plus waits.
// Backpressure: READ holds its address until bus_data_valid_i; nothing advances without cycle_enable_i.
module oam_dma #(
   parameter logic [15:0] DMA_REGISTER_ADDRESS = 16'h4014,
   parameter logic [15:0] OAM_DATA_ADDRESS     = 16'h2004
) (
   input  logic        clock_i,
   input  logic        reset_n_i,
   input  logic        cycle_enable_i,
   input  logic [15:0] cpu_address_i,
   input  logic        cpu_address_valid_i,
   input  logic [7:0]  cpu_data_i,
   input  logic        cpu_data_valid_i,
   output logic [7:0]  cpu_data_o,
   output logic        cpu_data_valid_o,
   output logic        cpu_halt_o,
   output logic [15:0] bus_address_o,
   output logic        bus_address_valid_o,
   output logic [7:0]  bus_data_o,
   output logic        bus_data_valid_o,
   input  logic [7:0]  bus_data_i,
   input  logic        bus_data_valid_i,
   output logic        busy_o
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] HALT  = 3'd1;
   localparam logic [2:0] ALIGN = 3'd2;
   localparam logic [2:0] READ  = 3'd3;
   localparam logic [2:0] WRITE = 3'd4;

   logic [2:0] state;
   logic [7:0] page;
   logic [7:0] index;
   logic [7:0] latch;
   logic       parity;
   logic       trigger;

   assign trigger = (state == IDLE) && cpu_address_valid_i && cpu_data_valid_i &&
                    (cpu_address_i == DMA_REGISTER_ADDRESS);

   // Sequencer: every register advances only on CPU-cycle clocks; parity tracks CPU cycle phase.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state  <= IDLE;
         page   <= 8'h00;
         index  <= 8'h00;
         latch  <= 8'h00;
         parity <= 1'b0;
      end else if (cycle_enable_i) begin
         parity <= ~parity;
         case (state)
            IDLE: begin
               if (trigger) begin
                  page  <= cpu_data_i;
                  index <= 8'h00;
                  state <= HALT;
               end
            end
            // An odd phase needs one dummy cycle so reads land on the read half of the pair.
            HALT:  state <= parity ? ALIGN : READ;
            ALIGN: state <= READ;
            READ: begin
               if (bus_data_valid_i) begin
                  latch <= bus_data_i;
                  state <= WRITE;
               end
            end
            WRITE: begin
               index <= index + 8'h01;
               state <= (index == 8'hFF) ? IDLE : READ;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus mux: pass-through when idle, DMA-driven otherwise; async reset returns the bus at once.
   always_comb begin
      bus_address_o       = cpu_address_i;
      bus_address_valid_o = cpu_address_valid_i;
      bus_data_o          = cpu_data_i;
      bus_data_valid_o    = cpu_data_valid_i;
      cpu_data_valid_o    = 1'b0;
      case (state)
         IDLE: cpu_data_valid_o = bus_data_valid_i;
         READ: begin
            bus_address_o       = {page, index};
            bus_address_valid_o = 1'b1;
            bus_data_o          = latch;
            bus_data_valid_o    = 1'b0;
         end
         WRITE: begin
            bus_address_o       = OAM_DATA_ADDRESS;
            bus_address_valid_o = 1'b1;
            bus_data_o          = latch;
            bus_data_valid_o    = 1'b1;
         end
         default: begin
            bus_address_o       = 16'h0000;
            bus_address_valid_o = 1'b0;
            bus_data_o          = 8'h00;
            bus_data_valid_o    = 1'b0;
         end
      endcase
   end

   assign cpu_data_o = bus_data_i;
   assign busy_o     = (state != IDLE);
   assign cpu_halt_o = busy_o;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

   logic        clock_i = 1'b0;
   logic        reset_n_i;
   logic        cycle_enable_i = 1'b0;
   logic [15:0] cpu_address_i;
   logic        cpu_address_valid_i;
   logic [7:0]  cpu_data_i;
   logic        cpu_data_valid_i;
   logic [7:0]  cpu_data_o;
   logic        cpu_data_valid_o;
   logic        cpu_halt_o;
   logic [15:0] bus_address_o;
   logic        bus_address_valid_o;
   logic [7:0]  bus_data_o;
   logic        bus_data_valid_o;
   logic [7:0]  bus_data_i;
   logic        bus_data_valid_i;
   logic        busy_o;

   oam_dma dut (
      .clock_i(clock_i), .reset_n_i(reset_n_i), .cycle_enable_i(cycle_enable_i),
      .cpu_address_i(cpu_address_i), .cpu_address_valid_i(cpu_address_valid_i),
      .cpu_data_i(cpu_data_i), .cpu_data_valid_i(cpu_data_valid_i),
      .cpu_data_o(cpu_data_o), .cpu_data_valid_o(cpu_data_valid_o),
      .cpu_halt_o(cpu_halt_o), .bus_address_o(bus_address_o),
      .bus_address_valid_o(bus_address_valid_o), .bus_data_o(bus_data_o),
      .bus_data_valid_o(bus_data_valid_o), .bus_data_i(bus_data_i),
      .bus_data_valid_i(bus_data_valid_i), .busy_o(busy_o)
   );

   always #5 clock_i = ~clock_i;

   // CPU cycle divider: enable high for one clock out of every two.
   initial forever begin
      @(posedge clock_i);
      #1 cycle_enable_i = ~cycle_enable_i;
   end

   typedef struct packed { logic [15:0] src; logic [7:0] dat; } exp_t;
   exp_t exp_q[$];

   int checks = 0;
   int failures = 0;
   int halt_cnt = 0;
   int wr_cnt = 0;
   int ecount;
   logic [15:0] wait_addr = 16'h0000;
   int wait_arm = 0;
   int wait_used = 0;
   logic stall;

   function automatic logic [7:0] mem_f(input logic [15:0] a);
      return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
   endfunction

   // Bus memory model with optional wait states on one address.
   assign stall = (bus_address_o == wait_addr) && (wait_used < wait_arm);
   assign bus_data_i = mem_f(bus_address_o);
   assign bus_data_valid_i = bus_address_valid_o && !bus_data_valid_o && !stall;

   always @(posedge clock_i)
      if (cycle_enable_i && busy_o && bus_address_valid_o && !bus_data_valid_o && stall)
         wait_used <= wait_used + 1;

   // Count of completed CPU cycles since reset (its LSB is the expected phase).
   always @(posedge clock_i or negedge reset_n_i)
      if (!reset_n_i) ecount <= 0;
      else if (cycle_enable_i) ecount <= ecount + 1;

   task automatic check(input string nm, input logic ok, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: scoreboard against DMA reads and OAM writes.
   always @(negedge clock_i) begin
      if (reset_n_i && cycle_enable_i) begin
         if (cpu_halt_o) halt_cnt++;
         if (busy_o && bus_address_valid_o && !bus_data_valid_o && bus_data_valid_i) begin
            if (exp_q.size() == 0) check("read_unexpected", 1'b0, {16'h0, bus_address_o}, 0);
            else check("read_addr", bus_address_o == exp_q[0].src, {16'h0, bus_address_o}, {16'h0, exp_q[0].src});
         end
         if (busy_o && bus_address_valid_o && bus_data_valid_o) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("spurious_write", 1'b0, {16'h0, bus_address_o}, 0);
            else begin
               exp_t e;
               e = exp_q.pop_front();
               check("write_addr", bus_address_o == 16'h2004, {16'h0, bus_address_o}, 32'h2004);
               check("write_data", bus_data_o == e.dat, {24'h0, bus_data_o}, {24'h0, e.dat});
            end
         end
      end
   end

   task automatic next_en();
      do @(negedge clock_i); while (!cycle_enable_i);
   endtask

   task automatic cpu_release();
      @(posedge clock_i);
      #1;
      cpu_address_valid_i = 1'b0;
      cpu_data_valid_i = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      next_en();
      cpu_address_i = a; cpu_data_i = d;
      cpu_address_valid_i = 1'b1; cpu_data_valid_i = 1'b1;
      cpu_release();
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      @(negedge clock_i);
      while (busy_o && n < 3000) begin @(negedge clock_i); n++; end
      check({nm, "_done"}, !busy_o && !cpu_halt_o, {31'h0, busy_o}, 0);
   endtask

   // Trigger a copy of page pg in a cycle whose phase LSB is ph; optional retrigger mid-transfer.
   task automatic start_xfer(input logic [7:0] pg, input bit ph);
      do next_en(); while (ecount[0] != ph);
      for (int i = 0; i < 256; i++) begin
         logic [15:0] s;
         s = {pg, i[7:0]};
         exp_q.push_back({s, mem_f(s)});
      end
      cpu_address_i = 16'h4014; cpu_data_i = pg;
      cpu_address_valid_i = 1'b1; cpu_data_valid_i = 1'b1;
      #1;
      check("trigger_passthru", bus_address_o == 16'h4014 && bus_data_valid_o && bus_data_o == pg && !cpu_halt_o,
            {bus_address_o, bus_data_o, 7'h0, bus_data_valid_o}, {16'h4014, pg, 8'h01});
      cpu_release();
   endtask

   task automatic run_xfer(input string nm, input logic [7:0] pg, input bit ph, input int waits, input bit retrig);
      int h0, w0, req;
      h0 = halt_cnt; w0 = wr_cnt;
      start_xfer(pg, ph);
      if (retrig) begin
         repeat (50) next_en();
         cpu_write(16'h4014, 8'h05);
      end
      wait_done(nm);
      req = 513 + (ph ? 0 : 1) + waits;
      check({nm, "_halted"}, (halt_cnt - h0) == req, halt_cnt - h0, req);
      check({nm, "_writes"}, (wr_cnt - w0) == 256, wr_cnt - w0, 256);
      check({nm, "_drained"}, exp_q.size() == 0, exp_q.size(), 0);
   endtask

   initial begin
      int w0, n;
      reset_n_i = 1'b0;
      cpu_address_i = 16'h0; cpu_address_valid_i = 1'b0;
      cpu_data_i = 8'h0; cpu_data_valid_i = 1'b0;
      #23 reset_n_i = 1'b1;
      @(negedge clock_i);
      check("reset_halt", !cpu_halt_o, {31'h0, cpu_halt_o}, 0);
      check("reset_busy", !busy_o, {31'h0, busy_o}, 0);
      // CPU read passes through while idle.
      next_en();
      cpu_address_i = 16'h8000; cpu_address_valid_i = 1'b1;
      #1;
      check("read_passthru_addr", bus_address_o == 16'h8000 && bus_address_valid_o && !bus_data_valid_o,
            {bus_address_o, 15'h0, bus_address_valid_o}, {16'h8000, 16'h1});
      check("read_passthru_data", cpu_data_valid_o && cpu_data_o == mem_f(16'h8000),
            {23'h0, cpu_data_valid_o, cpu_data_o}, {24'h1, mem_f(16'h8000)});
      cpu_release();

      run_xfer("even", 8'h02, 1'b1, 0, 1'b0);
      run_xfer("odd", 8'h02, 1'b0, 0, 1'b0);
      wait_addr = 16'h0310; wait_arm = 3;
      run_xfer("wait", 8'h03, 1'b1, 3, 1'b0);
      check("wait_used", wait_used == 3, wait_used, 3);
      run_xfer("page_ff", 8'hFF, 1'b1, 0, 1'b1);

      // Abort mid-transfer with an asynchronous reset.
      w0 = wr_cnt;
      start_xfer(8'h40, 1'b1);
      n = 0;
      while ((wr_cnt - w0) < 100 && n < 3000) begin @(negedge clock_i); n++; end
      check("abort_reached100", (wr_cnt - w0) >= 100, wr_cnt - w0, 100);
      #2 reset_n_i = 1'b0;
      #1;
      check("abort_halt_async", !cpu_halt_o && !busy_o, {30'h0, cpu_halt_o, busy_o}, 0);
      check("abort_bus_returned", bus_address_valid_o == cpu_address_valid_i && !bus_data_valid_o,
            {30'h0, bus_address_valid_o, bus_data_valid_o}, {31'h0, cpu_address_valid_i});
      exp_q.delete();
      w0 = wr_cnt;
      repeat (3) @(negedge clock_i);
      #3 reset_n_i = 1'b1;
      repeat (10) next_en();
      check("abort_no_writes", wr_cnt == w0, wr_cnt - w0, 0);
      run_xfer("after_abort", 8'h41, 1'b0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog.
   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
